// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Supervises the SDRAM-controller 2x PLL from the PLL reference clock:
//   holds the PLL in powerdown, waits for LOCK, qualifies it as stable,
//   then releases the controller reset. Lock timeouts power-cycle the PLL
//   up to MAX_RETRIES times before a sticky failure is declared.
//
// Ports
//   CLK             in   reference clock (same source as the PLL input clock)
//   RESETN          in   asynchronous active-low reset
//   PLL_LOCK        in   PLL lock indicator, asynchronous to CLK
//   RESTART         in   single-cycle request to re-run the full sequence
//   PLL_POWERDOWN_N out  to PLL powerdown input, 0 = powered down
//   SYS_RESETN      out  active-low reset to the SDRAM controller (1 only in RUN)
//   PLL_READY       out  high in RUN
//   PLL_FAIL        out  sticky failure flag (high in FAIL)
//   RETRY_CNT       out  retries used in the current sequence
//   LOSS_CNT        out  lock-loss events seen in RUN, saturating at 255
module pll_lock_sequencer #(
  parameter int unsigned PWRDN_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       PLL_LOCK,
  input  logic       RESTART,
  output logic       PLL_POWERDOWN_N,
  output logic       SYS_RESETN,
  output logic       PLL_READY,
  output logic       PLL_FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam logic [CNT_WIDTH-1:0] PWRDN_LAST   = CNT_WIDTH'(PWRDN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic                 lock_meta_q;
  logic                 lock_s_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           retry_q, retry_d;
  logic [7:0]           loss_q, loss_d;
  logic                 pdn_n_q, pdn_n_d;
  logic                 sys_resetn_q, sys_resetn_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;

  // Two-flop synchroniser for the asynchronous lock indicator.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_PWRDN;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pdn_n_q      <= 1'b0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pdn_n_q      <= pdn_n_d;
      sys_resetn_q <= sys_resetn_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (RESTART) begin
      // Restart overrides every other transition; LOSS_CNT is kept.
      state_d = ST_PWRDN;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PWRDN: begin
          if (cnt_q == PWRDN_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PWRDN;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != '1) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PWRDN;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they switch on the
    // same edge as the state register.
    pdn_n_d      = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    sys_resetn_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  assign PLL_POWERDOWN_N = pdn_n_q;
  assign SYS_RESETN      = sys_resetn_q;
  assign PLL_READY       = ready_q;
  assign PLL_FAIL        = fail_q;
  assign RETRY_CNT       = retry_q;
  assign LOSS_CNT        = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;
  localparam int PW = 4;
  localparam int ST = 8;
  localparam int TO = 32;
  localparam int MR = 2;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       RESTART = 1'b0;
  logic       PLL_POWERDOWN_N, SYS_RESETN, PLL_READY, PLL_FAIL;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  always #5 CLK = ~CLK;

  pll_lock_sequencer #(
    .PWRDN_CYCLES(PW),
    .LOCK_STABLE_CYCLES(ST),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR),
    .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .PLL_LOCK(PLL_LOCK),
    .RESTART(RESTART),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .SYS_RESETN(SYS_RESETN),
    .PLL_READY(PLL_READY),
    .PLL_FAIL(PLL_FAIL),
    .RETRY_CNT(RETRY_CNT),
    .LOSS_CNT(LOSS_CNT)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which phase of the sequence we are in and how
  // many edges have been spent there; lock is seen through a 2-edge delay.
  string m_phase;
  int    m_elapsed, m_retries, m_losses;
  bit    m_s1, m_s2;

  function automatic void model_reset();
    m_phase = "PWRDN"; m_elapsed = 0; m_retries = 0; m_losses = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endfunction

  function automatic void model_step(bit lk, bit rs);
    bit ls;
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    if (rs) begin
      m_phase = "PWRDN"; m_elapsed = 0; m_retries = 0;
    end else if (m_phase == "PWRDN") begin
      m_elapsed++;
      if (m_elapsed == PW) begin m_phase = "WAIT"; m_elapsed = 0; end
    end else if (m_phase == "WAIT") begin
      if (ls) begin
        m_phase = "STABLE"; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == TO) begin
          m_elapsed = 0;
          if (m_retries == MR) m_phase = "FAIL";
          else begin m_retries++; m_phase = "PWRDN"; end
        end
      end
    end else if (m_phase == "STABLE") begin
      if (!ls) begin
        m_phase = "WAIT"; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == ST) begin m_phase = "RUN"; m_elapsed = 0; m_retries = 0; end
      end
    end else if (m_phase == "RUN") begin
      if (!ls) begin
        m_phase = "WAIT"; m_elapsed = 0;
        if (m_losses < 255) m_losses++;
      end
    end
  endfunction

  task automatic compare_model();
    bit up;
    up = (m_phase == "WAIT") || (m_phase == "STABLE") || (m_phase == "RUN");
    check("model.PLL_POWERDOWN_N", int'(PLL_POWERDOWN_N), int'(up));
    check("model.SYS_RESETN", int'(SYS_RESETN), int'(m_phase == "RUN"));
    check("model.PLL_READY", int'(PLL_READY), int'(m_phase == "RUN"));
    check("model.PLL_FAIL", int'(PLL_FAIL), int'(m_phase == "FAIL"));
    check("model.RETRY_CNT", int'(RETRY_CNT), m_retries);
    check("model.LOSS_CNT", int'(LOSS_CNT), m_losses);
  endtask

  task automatic tick();
    bit l, r;
    l = PLL_LOCK; r = RESTART;
    @(posedge CLK); #1;
    model_step(l, r);
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".PLL_POWERDOWN_N"}, int'(PLL_POWERDOWN_N), 0);
    check({tag, ".SYS_RESETN"}, int'(SYS_RESETN), 0);
    check({tag, ".PLL_READY"}, int'(PLL_READY), 0);
    check({tag, ".PLL_FAIL"}, int'(PLL_FAIL), 0);
    check({tag, ".RETRY_CNT"}, int'(RETRY_CNT), 0);
    check({tag, ".LOSS_CNT"}, int'(LOSS_CNT), 0);
  endtask

  task automatic apply_reset();
    RESETN = 1'b0; RESTART = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RESETN = 1'b1;
    model_reset();
    check_reset_values("reset");
  endtask

  // Mid-cycle reset pulse that never straddles a clock edge.
  task automatic async_reset_pulse(input string tag);
    #2 RESETN = 1'b0;
    #1 check_reset_values(tag);
    #2 RESETN = 1'b1;
    model_reset();
  endtask

  task automatic wait_srn(input logic val, input int bound, output int n);
    n = 0;
    while (SYS_RESETN !== val && n < bound) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    bit rst; bit lock; bit restart; int n;
    bit pdn; bit srn; bit rdy; bit fail; int retry;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    int run_left;
    bit lvl;

    // Nominal lock-up, then timeout/retry/fail, then RESTART out of FAIL.
    tbl.push_back('{1, 1, 0,  3, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  8, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  1, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 20, 1, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0,  3, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,  1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 31, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0,  1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0,  3, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0,  1, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 32, 0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0,  4, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 31, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0,  1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 0, 1,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  4, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,  9, 1, 1, 1, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) apply_reset();
      PLL_LOCK = tbl[i].lock;
      RESTART  = tbl[i].restart;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        RESTART = 1'b0;
      end
      check($sformatf("vec%0d.PLL_POWERDOWN_N", i), int'(PLL_POWERDOWN_N), int'(tbl[i].pdn));
      check($sformatf("vec%0d.SYS_RESETN", i), int'(SYS_RESETN), int'(tbl[i].srn));
      check($sformatf("vec%0d.PLL_READY", i), int'(PLL_READY), int'(tbl[i].rdy));
      check($sformatf("vec%0d.PLL_FAIL", i), int'(PLL_FAIL), int'(tbl[i].fail));
      check($sformatf("vec%0d.RETRY_CNT", i), int'(RETRY_CNT), tbl[i].retry);
    end

    // Unstable lock: 3-cycle drop while in STABLE restarts qualification.
    apply_reset();
    PLL_LOCK = 1'b1;
    repeat (8) tick();
    check("unstable.srn_before_drop", int'(SYS_RESETN), 0);
    PLL_LOCK = 1'b0;
    repeat (3) tick();
    PLL_LOCK = 1'b1;
    wait_srn(1'b1, 40, n);
    check("unstable.relock_edges", n, 11);
    check("unstable.RETRY_CNT", int'(RETRY_CNT), 0);

    // Lock loss in RUN and relock.
    PLL_LOCK = 1'b0;
    wait_srn(1'b0, 10, n);
    check("loss.fall_edges", n, 3);
    check("loss.LOSS_CNT", int'(LOSS_CNT), 1);
    check("loss.PLL_READY", int'(PLL_READY), 0);
    PLL_LOCK = 1'b1;
    wait_srn(1'b1, 40, n);
    check("loss.relock_edges", n, 11);

    // RESTART on the very edge RUN would see the lock drop.
    PLL_LOCK = 1'b0;
    repeat (2) tick();
    check("rs_drop.srn_still_high", int'(SYS_RESETN), 1);
    RESTART = 1'b1;
    tick();
    RESTART = 1'b0;
    check("rs_drop.PLL_POWERDOWN_N", int'(PLL_POWERDOWN_N), 0);
    check("rs_drop.SYS_RESETN", int'(SYS_RESETN), 0);
    check("rs_drop.PLL_FAIL", int'(PLL_FAIL), 0);
    check("rs_drop.RETRY_CNT", int'(RETRY_CNT), 0);
    check("rs_drop.LOSS_CNT", int'(LOSS_CNT), 1);
    PLL_LOCK = 1'b1;
    wait_srn(1'b1, 60, n);
    check("rs_drop.relock_edges", n, 13);

    // Drive 300 lock losses; LOSS_CNT must saturate.
    for (int i = 0; i < 300; i++) begin
      PLL_LOCK = 1'b0;
      wait_srn(1'b0, 10, n);
      PLL_LOCK = 1'b1;
      wait_srn(1'b1, 40, n);
    end
    check("sat.LOSS_CNT", int'(LOSS_CNT), 255);
    check("sat.SYS_RESETN", int'(SYS_RESETN), 1);

    // Asynchronous reset while in RUN, then while in STABLE.
    async_reset_pulse("rst_run");
    repeat (3) tick();
    check("rst_run.pdn_low_edge3", int'(PLL_POWERDOWN_N), 0);
    tick();
    check("rst_run.pdn_high_edge4", int'(PLL_POWERDOWN_N), 1);
    repeat (3) tick();
    async_reset_pulse("rst_stable");
    wait_srn(1'b1, 40, n);
    check("rst_stable.lockup_edges", n, 13);

    // Randomised lock behaviour with occasional RESTART, checked every edge.
    apply_reset();
    run_left = 0;
    lvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        lvl = ($urandom_range(0, 99) < 65);
        run_left = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 120));
      end
      run_left--;
      PLL_LOCK = lvl;
      RESTART = ($urandom_range(0, 299) == 0);
      tick();
      RESTART = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
